// File: rtl/mtm_alu_deserializer.sv
// Serial receive front-end of mtm_Alu: rebuilds B, A and opcode from 11-bit packets,
// validates packet count, CRC-4 and opcode, and reports a one-cycle data or error pulse.
module mtm_alu_deserializer #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter bit CRC_CHECK_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic        data_valid,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? IW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, WAIT_HI} state_t;

  state_t        state, next_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          is_cmd;
  logic [3:0]    pkt_cnt;
  logic          bad_frame;
  logic [63:0]   frame_reg;
  logic [IW-1:0] idle_cnt;

  logic          pkt_done;
  logic          cmd_done;
  logic [2:0]    cmd_op;
  logic [3:0]    crc_calc;
  logic          op_legal;
  logic [2:0]    cmd_flags;
  logic          timeout_hit;

  // CRC-4, polynomial x^4+x+1, zero init, MSB first
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!sin) next_state = TYPE;
      TYPE:    next_state = DATA;
      DATA:    if (bit_cnt == 3'd7) next_state = STOP;
      STOP:    next_state = sin ? IDLE : WAIT_HI;
      WAIT_HI: if (sin) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pkt_done = (state == STOP) && sin;
    cmd_done = pkt_done && is_cmd;
    cmd_op   = shift_reg[6:4];
    crc_calc = crc4({frame_reg, 1'b1, cmd_op});
    op_legal = 1'b0;
    case (cmd_op)
      3'b000, 3'b001, 3'b100, 3'b101: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
    if (pkt_cnt != 4'd8 || bad_frame)
      cmd_flags = 3'b100;
    else if (CRC_CHECK_EN && (crc_calc != shift_reg[3:0]))
      cmd_flags = 3'b010;
    else if (!op_legal)
      cmd_flags = 3'b001;
    else
      cmd_flags = 3'b000;
    timeout_hit = (TIMEOUT_CYCLES > 0) && (state == IDLE) && sin &&
                  (pkt_cnt != 4'd0) && (idle_cnt == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      is_cmd     <= 1'b0;
      pkt_cnt    <= '0;
      bad_frame  <= 1'b0;
      frame_reg  <= '0;
      idle_cnt   <= '0;
      A          <= '0;
      B          <= '0;
      op         <= '0;
      data_valid <= 1'b0;
      err_valid  <= 1'b0;
      err_flags  <= '0;
    end else begin
      data_valid <= 1'b0;
      err_valid  <= 1'b0;

      if (state == IDLE) begin
        if (!sin)                idle_cnt <= '0;
        else if (idle_cnt != '1) idle_cnt <= idle_cnt + IW'(1);
      end

      case (state)
        TYPE: begin
          is_cmd  <= sin;
          bit_cnt <= '0;
        end
        DATA: begin
          shift_reg <= {shift_reg[6:0], sin};
          bit_cnt   <= bit_cnt + 3'd1;
        end
        STOP: begin
          if (!sin) begin
            bad_frame <= 1'b1;
          end else if (!is_cmd) begin
            // a ninth data byte poisons the frame instead of shifting out B
            if (pkt_cnt != 4'd8) begin
              frame_reg <= {frame_reg[55:0], shift_reg};
              pkt_cnt   <= pkt_cnt + 4'd1;
            end else begin
              bad_frame <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (cmd_done) begin
        pkt_cnt   <= '0;
        bad_frame <= 1'b0;
        if (cmd_flags == 3'b000) begin
          data_valid <= 1'b1;
          B          <= frame_reg[63:32];
          A          <= frame_reg[31:0];
          op         <= cmd_op;
        end else begin
          err_valid <= 1'b1;
          err_flags <= cmd_flags;
        end
      end

      if (timeout_hit) begin
        pkt_cnt   <= '0;
        bad_frame <= 1'b0;
      end
    end
  end

endmodule
